// File: rtl/rain_pkg.sv
// Shared constants for the rain-game tick generator.
// Default lane/bucket/check periods, speed-band width and counter width.
package rain_pkg;

   localparam int N_LANES = 5;
   localparam int SPEED_W = 2;
   localparam int DEF_CNT_W = 24;

   localparam int DEF_LANE_PERIOD_0 = 1_250_000;
   localparam int DEF_LANE_PERIOD_1 = 1_000_000;
   localparam int DEF_LANE_PERIOD_2 = 833_333;
   localparam int DEF_LANE_PERIOD_3 = 625_000;
   localparam int DEF_LANE_PERIOD_4 = 500_000;
   localparam int DEF_BUCKET_PERIOD = 250_000;
   localparam int DEF_CHECK_PERIOD = 125_000;

   function automatic bit period_fits(input int p, input int w);
      return longint'(p) < (longint'(1) << w);
   endfunction

   // Fastest band divides by 8; it must still leave a period of 2
   // so a strobe can never be high on two adjacent cycles.
   function automatic bit lane_period_ok(input int p, input int w);
      return ((p >> 3) >= 2) && period_fits(p, w);
   endfunction

endpackage

// File: rtl/rain_tick_gen_tick_divider.sv
// Down-counting strobe divider: one-cycle tick every `period` enabled edges.
// Ports: clk, reset (async high), en, period (sampled at reload), tick.
module tick_divider
   import rain_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int RST_PERIOD = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   output logic             tick
);

   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   // A new period is only picked up on reload, so a speed change
   // never truncates or restarts the count in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= RST_LOAD;
         tick <= 1'b0;
      end else if (!en) begin
         tick <= 1'b0;
      end else if (cnt == '0) begin
         cnt  <= period - CNT_W'(1);
         tick <= 1'b1;
      end else begin
         cnt  <= cnt - CNT_W'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/rain_tick_gen.sv
// Strobe generator for the rain game: 5 lane fall ticks, bucket and check.
// Ports: clk12p5mhz_clk, reset, pause_switch, volume_level -> rain_tick,
//        bucket_tick, check_tick, speed_level.
module rain_tick_gen
   import rain_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int LANE_PERIOD_0 = DEF_LANE_PERIOD_0,
   parameter int LANE_PERIOD_1 = DEF_LANE_PERIOD_1,
   parameter int LANE_PERIOD_2 = DEF_LANE_PERIOD_2,
   parameter int LANE_PERIOD_3 = DEF_LANE_PERIOD_3,
   parameter int LANE_PERIOD_4 = DEF_LANE_PERIOD_4,
   parameter int BUCKET_PERIOD = DEF_BUCKET_PERIOD,
   parameter int CHECK_PERIOD = DEF_CHECK_PERIOD
) (
   input  logic               clk12p5mhz_clk,
   input  logic               reset,
   input  logic               pause_switch,
   input  logic [5:0]         volume_level,
   output logic [N_LANES-1:0] rain_tick,
   output logic               bucket_tick,
   output logic               check_tick,
   output logic [SPEED_W-1:0] speed_level
);

   localparam int LANE_P [N_LANES] = '{
      LANE_PERIOD_0, LANE_PERIOD_1, LANE_PERIOD_2,
      LANE_PERIOD_3, LANE_PERIOD_4
   };

   logic unused_volume_bits;
   assign unused_volume_bits = ^volume_level[3:0];

   // Top two volume bits select one of four 16-step bands.
   always_ff @(posedge clk12p5mhz_clk or posedge reset) begin
      if (reset) speed_level <= '0;
      else       speed_level <= volume_level[5:4];
   end

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      if (!lane_period_ok(LANE_P[i], CNT_W)) begin : g_bad
         $error("rain_tick_gen: lane %0d period %0d invalid",
                i, LANE_P[i]);
      end

      logic [CNT_W-1:0] lane_period;
      assign lane_period = CNT_W'(LANE_P[i]) >> speed_level;

      tick_divider #(
         .CNT_W      (CNT_W),
         .RST_PERIOD (LANE_P[i])
      ) u_lane (
         .clk    (clk12p5mhz_clk),
         .reset  (reset),
         .en     (~pause_switch),
         .period (lane_period),
         .tick   (rain_tick[i])
      );
   end

   if (!period_fits(BUCKET_PERIOD, CNT_W)) begin : g_bad_bucket
      $error("rain_tick_gen: BUCKET_PERIOD %0d too wide", BUCKET_PERIOD);
   end

   if (!period_fits(CHECK_PERIOD, CNT_W)) begin : g_bad_check
      $error("rain_tick_gen: CHECK_PERIOD %0d too wide", CHECK_PERIOD);
   end

   tick_divider #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (BUCKET_PERIOD)
   ) u_bucket (
      .clk    (clk12p5mhz_clk),
      .reset  (reset),
      .en     (1'b1),
      .period (CNT_W'(BUCKET_PERIOD)),
      .tick   (bucket_tick)
   );

   tick_divider #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (CHECK_PERIOD)
   ) u_check (
      .clk    (clk12p5mhz_clk),
      .reset  (reset),
      .en     (1'b1),
      .period (CNT_W'(CHECK_PERIOD)),
      .tick   (check_tick)
   );

endmodule

// File: tb/tb_rain_tick_gen.sv
// Directed bench for rain_tick_gen with short periods 16/20/24/32/40,
// bucket 8, check 4; edge k = k-th rising edge after reset release.
module tb_rain_tick_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       pause_switch;
   logic [5:0] volume_level;
   logic [4:0] rain_tick;
   logic       bucket_tick;
   logic       check_tick;
   logic [1:0] speed_level;

   int passed = 0;
   int total = 0;

   localparam int P [5] = '{16, 20, 24, 32, 40};

   always #5 clk = ~clk;

   rain_tick_gen #(
      .CNT_W         (24),
      .LANE_PERIOD_0 (16),
      .LANE_PERIOD_1 (20),
      .LANE_PERIOD_2 (24),
      .LANE_PERIOD_3 (32),
      .LANE_PERIOD_4 (40),
      .BUCKET_PERIOD (8),
      .CHECK_PERIOD  (4)
   ) dut (
      .clk12p5mhz_clk (clk),
      .reset          (reset),
      .pause_switch   (pause_switch),
      .volume_level   (volume_level),
      .rain_tick      (rain_tick),
      .bucket_tick    (bucket_tick),
      .check_tick     (check_tick),
      .speed_level    (speed_level)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [5:0] vol, input int hold);
      reset = 1'b1;
      pause_switch = 1'b0;
      volume_level = vol;
      repeat (hold) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] exp_r;
      reset = 1'b1;
      pause_switch = 1'b0;
      volume_level = 6'd0;
      for (int c = 0; c < 5; c++) begin
         step();
         total++;
         if ({rain_tick, bucket_tick, check_tick, speed_level} !== 9'd0)
            $display("FAIL reset_hold c=%0d got=%b%b%b%b exp=0", c,
                     rain_tick, bucket_tick, check_tick, speed_level);
         else passed++;
      end
      reset = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         step();
         for (int i = 0; i < 5; i++) exp_r[i] = (k % P[i] == 0);
         total++;
         if (rain_tick !== exp_r ||
             check_tick !== (k % 4 == 0) ||
             bucket_tick !== (k % 8 == 0))
            $display("FAIL base_cadence k=%0d got=%b/%b/%b exp=%b/%b/%b",
                     k, rain_tick, bucket_tick, check_tick, exp_r,
                     k % 8 == 0, k % 4 == 0);
         else passed++;
      end
   endtask

   task automatic test_fast_volume();
      logic [4:0] exp_r;
      start(6'd63, 3);
      for (int k = 1; k <= 60; k++) begin
         step();
         for (int i = 0; i < 5; i++)
            exp_r[i] = (k >= P[i]) && ((k - P[i]) % (P[i] >> 3) == 0);
         total++;
         if (rain_tick !== exp_r || speed_level !== 2'd3)
            $display("FAIL fast_volume k=%0d got=%b spd=%0d exp=%b spd=3",
                     k, rain_tick, speed_level, exp_r);
         else passed++;
      end
   endtask

   task automatic test_speed_change();
      logic [4:0] exp_r;
      logic [1:0] exp_s;
      start(6'd0, 3);
      for (int k = 1; k <= 44; k++) begin
         step();
         exp_s = (k >= 10) ? 2'd3 : 2'd0;
         for (int i = 0; i < 5; i++)
            exp_r[i] = (k >= P[i]) && ((k - P[i]) % (P[i] >> 3) == 0);
         total++;
         if (rain_tick !== exp_r || speed_level !== exp_s)
            $display("FAIL speed_change k=%0d got=%b spd=%0d exp=%b spd=%0d",
                     k, rain_tick, speed_level, exp_r, exp_s);
         else passed++;
         if (k == 9) volume_level = 6'd48;
      end
   endtask

   task automatic test_pause();
      logic [4:0] exp_r;
      start(6'd0, 3);
      for (int k = 1; k <= 64; k++) begin
         step();
         for (int i = 0; i < 5; i++)
            exp_r[i] = (k >= 28) && ((k - 20) % P[i] == 0);
         total++;
         if (rain_tick !== exp_r ||
             bucket_tick !== (k % 8 == 0) ||
             check_tick !== (k % 4 == 0))
            $display("FAIL pause k=%0d got=%b/%b/%b exp=%b/%b/%b",
                     k, rain_tick, bucket_tick, check_tick, exp_r,
                     k % 8 == 0, k % 4 == 0);
         else passed++;
         if (k == 7) pause_switch = 1'b1;
         if (k == 27) pause_switch = 1'b0;
      end
   endtask

   task automatic test_reset_pulse();
      start(6'd0, 3);
      repeat (12) step();
      reset = 1'b1;
      #1;
      total++;
      if ({rain_tick, bucket_tick, check_tick} !== 7'd0)
         $display("FAIL async_reset got=%b%b%b exp=0",
                  rain_tick, bucket_tick, check_tick);
      else passed++;
      step();
      reset = 1'b0;
      for (int k = 1; k <= 34; k++) begin
         step();
         total++;
         if (rain_tick[0] !== (k == 16 || k == 32) ||
             check_tick !== (k % 4 == 0))
            $display("FAIL after_pulse k=%0d got=%b/%b exp=%b/%b",
                     k, rain_tick[0], check_tick, k == 16 || k == 32,
                     k % 4 == 0);
         else passed++;
      end
   endtask

   task automatic test_counts();
      int cnt [5];
      int exp_c [5];
      int nb;
      int nc;
      int wide;
      logic [6:0] prev;
      exp_c = '{30, 24, 20, 15, 12};
      for (int i = 0; i < 5; i++) cnt[i] = 0;
      nb = 0;
      nc = 0;
      wide = 0;
      prev = '0;
      start(6'd0, 3);
      for (int k = 1; k <= 480; k++) begin
         step();
         for (int i = 0; i < 5; i++) if (rain_tick[i] === 1'b1) cnt[i]++;
         if (bucket_tick === 1'b1) nb++;
         if (check_tick === 1'b1) nc++;
         if ((prev & {rain_tick, bucket_tick, check_tick}) != 7'd0) wide++;
         prev = {rain_tick, bucket_tick, check_tick};
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (cnt[i] !== exp_c[i])
            $display("FAIL lane_count lane=%0d got=%0d exp=%0d",
                     i, cnt[i], exp_c[i]);
         else passed++;
      end
      total++;
      if (nb !== 60 || nc !== 120)
         $display("FAIL bc_count got=%0d/%0d exp=60/120", nb, nc);
      else passed++;
      total++;
      if (wide !== 0)
         $display("FAIL strobe_width got=%0d wide exp=0", wide);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_fast_volume();
      test_speed_change();
      test_pause();
      test_reset_pulse();
      test_counts();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
